// File: rtl/riscv_constants.sv
// Shared operand-select encodings for the RISC-V datapath.
// OP2_RS2 and OP2_IMS keep the legacy 2-way mux encodings; OP2_IMI,
// OP2_IMU and OP2_FOUR are appended so old decode tables stay valid.
package riscv_constants;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_t;

    typedef enum logic [2:0] {
        OP2_RS2  = 3'd0,
        OP2_IMS  = 3'd1,
        OP2_IMI  = 3'd2,
        OP2_IMU  = 3'd3,
        OP2_FOUR = 3'd4
    } op2_sel_t;

endpackage

// File: rtl/riscv_fwd_unit.sv
// Resolves one source register against the forwarding network.
// Ports:
//   rs_addr / rf_data        : source index and register-file read data
//   fwd_valid/busy/waddr/wdata : producer vectors, index 0 youngest
//   value                    : resolved operand (x0 always reads 0)
//   busy                     : the winning producer has no result yet
module riscv_fwd_unit
    import riscv_constants::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [REG_ADDR_W-1:0]                rs_addr,
    input  logic [XLEN-1:0]                      rf_data,
    input  logic [NUM_FWD-1:0]                   fwd_valid,
    input  logic [NUM_FWD-1:0]                   fwd_busy,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD-1:0][XLEN-1:0]         fwd_wdata,
    output logic [XLEN-1:0]                      value,
    output logic                                 busy
);

    // Walk from oldest to youngest so the youngest match overwrites;
    // its busy flag is the only one that matters (shadowed loads are
    // not hazards).
    always_comb begin
        value = rf_data;
        busy  = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_waddr[i] == rs_addr)) begin
                value = fwd_wdata[i];
                busy  = fwd_busy[i];
            end
        end
        if (rs_addr == '0) begin
            value = '0;
            busy  = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_operand_stage.sv
// ID/EX operand stage: selects ALU operands (with forwarding) and holds
// them in a valid/ready pipeline register. Handles flush and load-use
// stall. Optional counters under RISCV_OPERAND_STAGE_PERF_EN.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready   : decode handshake
//   op1_sel, op2_sel, rs*_addr, rs*_data, pc, imm_* : operand sources
//   fwd_*               : forwarding network, index 0 highest priority
//   out_valid/out_ready : execute handshake
//   out_op1, out_op2, out_store_data : registered operands
//   stall_cnt, flush_cnt (PERF_EN only) : saturating event counters
module riscv_operand_stage
    import riscv_constants::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  op1_sel_t                             op1_sel,
    input  op2_sel_t                             op2_sel,
    input  logic [REG_ADDR_W-1:0]                rs1_addr,
    input  logic [REG_ADDR_W-1:0]                rs2_addr,
    input  logic [XLEN-1:0]                      rs1_data,
    input  logic [XLEN-1:0]                      rs2_data,
    input  logic [XLEN-1:0]                      pc,
    input  logic [XLEN-1:0]                      imm_i_sext,
    input  logic [XLEN-1:0]                      imm_s_sext,
    input  logic [XLEN-1:0]                      imm_u_shifted,
    input  logic [NUM_FWD-1:0]                   fwd_valid,
    input  logic [NUM_FWD-1:0]                   fwd_busy,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD-1:0][XLEN-1:0]         fwd_wdata,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [XLEN-1:0]                      out_op1,
    output logic [XLEN-1:0]                      out_op2,
    output logic [XLEN-1:0]                      out_store_data
`ifdef RISCV_OPERAND_STAGE_PERF_EN
    ,
    output logic [31:0]                          stall_cnt,
    output logic [31:0]                          flush_cnt
`endif
);

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_busy, rs2_busy;
    logic            rs1_used, rs2_used, hazard, accept;
    logic [XLEN-1:0] op1_nxt, op2_nxt;

    riscv_fwd_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .rs_addr   (rs1_addr),
        .rf_data   (rs1_data),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .value     (rs1_val),
        .busy      (rs1_busy)
    );

    riscv_fwd_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .rs_addr   (rs2_addr),
        .rf_data   (rs2_data),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .value     (rs2_val),
        .busy      (rs2_busy)
    );

    // Stores read rs2 for store data even though op2 is the immediate.
    assign rs1_used = (op1_sel == OP1_RS1);
    assign rs2_used = (op2_sel == OP2_RS2) || (op2_sel == OP2_IMS);
    assign hazard   = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1_nxt = '0;
        case (op1_sel)
            OP1_RS1: op1_nxt = rs1_val;
            OP1_PC:  op1_nxt = pc;
            default: op1_nxt = '0;
        endcase
    end

    always_comb begin
        op2_nxt = '0;
        case (op2_sel)
            OP2_RS2:  op2_nxt = rs2_val;
            OP2_IMI:  op2_nxt = imm_i_sext;
            OP2_IMS:  op2_nxt = imm_s_sext;
            OP2_IMU:  op2_nxt = imm_u_shifted;
            OP2_FOUR: op2_nxt = XLEN'(4);
            default:  op2_nxt = '0;
        endcase
    end

    // flush ranks below rst only; accept already excludes flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_op1        <= '0;
            out_op2        <= '0;
            out_store_data <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_op1        <= op1_nxt;
            out_op2        <= op2_nxt;
            out_store_data <= rs2_val;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

`ifdef RISCV_OPERAND_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_valid && hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != '1))              flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_operand_stage.sv
module tb_riscv_operand_stage;
    import riscv_constants::*;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    op1_sel_t op1_sel;
    op2_sel_t op2_sel;
    logic [4:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, pc, imm_i_sext, imm_s_sext, imm_u_shifted;
    logic [NUM_FWD-1:0] fwd_valid, fwd_busy;
    logic [NUM_FWD-1:0][4:0] fwd_waddr;
    logic [NUM_FWD-1:0][XLEN-1:0] fwd_wdata;
    logic [XLEN-1:0] out_op1, out_op2, out_store_data;
`ifdef RISCV_OPERAND_STAGE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    riscv_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1_sel(op1_sel), .op2_sel(op2_sel),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm_i_sext(imm_i_sext), .imm_s_sext(imm_s_sext),
        .imm_u_shifted(imm_u_shifted),
        .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_store_data(out_store_data)
`ifdef RISCV_OPERAND_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] op1, op2, sd; } exp_t;
    typedef struct { string name; logic [31:0] act, exp; } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    exp_t nxt;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
        end
    endtask

    // Monitor: drains direct checks, then scores the presented output.
    initial begin
        chk_t c;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                cmp(c.name, c.act, c.exp);
            end
            if (rst) begin
                exp_q.delete();
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    cmp("out_op1", out_op1, e.op1);
                    cmp("out_op2", out_op2, e.op2);
                    cmp("out_store_data", out_store_data, e.sd);
                    if (out_ready || flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic dchk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_q.push_back('{n, a, e});
    endtask

    task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        nxt = '{a, b, s};
    endtask

    // Inputs are driven at negedge; step records an accept just before the edge.
    task automatic step();
        #3;
        if (!rst && in_valid && in_ready) exp_q.push_back(nxt);
        @(negedge clk);
    endtask

    task automatic ready_is(input string n, input logic e);
        #1;
        dchk(n, 32'(in_ready), 32'(e));
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1;
        op1_sel = OP1_ZERO; op2_sel = OP2_FOUR;
        rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
        pc = 0; imm_i_sext = 0; imm_s_sext = 0; imm_u_shifted = 0;
        fwd_valid = 0; fwd_busy = 0; fwd_waddr = '0; fwd_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(); rst = 1;
        step(); step();
        rst = 0;
        dchk("rst_valid", 32'(out_valid), 0);
        dchk("rst_op1", out_op1, 0);
        dchk("rst_op2", out_op2, 0);
        dchk("rst_sd", out_store_data, 0);

        // PC + I-immediate
        op1_sel = OP1_PC; pc = 32'h100; op2_sel = OP2_IMI; imm_i_sext = 32'hFFFF_FFF0; in_valid = 1;
        expect_out(32'h100, 32'hFFFF_FFF0, 0);
        ready_is("rdy_v1", 1);
        step();
        dchk("lat_valid", 32'(out_valid), 1);

        // forwarding priority
        idle(); in_valid = 1;
        op1_sel = OP1_RS1; rs1_addr = 5; rs1_data = 1;
        op2_sel = OP2_RS2; rs2_addr = 5; rs2_data = 2;
        fwd_valid = 2'b11; fwd_waddr[0] = 5; fwd_wdata[0] = 32'hAA;
        fwd_waddr[1] = 5; fwd_wdata[1] = 32'hBB;
        expect_out(32'hAA, 32'hAA, 32'hAA); step();
        fwd_waddr[0] = 6;
        expect_out(32'hBB, 32'hBB, 32'hBB); step();
        // x0 never forwards
        rs1_addr = 0; rs1_data = 32'h77; fwd_waddr[0] = 0; fwd_waddr[1] = 0; fwd_wdata[0] = 32'hCC;
        op2_sel = OP2_FOUR; rs2_addr = 9; rs2_data = 32'h99;
        expect_out(0, 4, 32'h99); step();

        // busy older match shadowed by younger ready match
        idle(); in_valid = 1; op2_sel = OP2_RS2; rs2_addr = 7; rs2_data = 32'h70;
        fwd_valid = 2'b11; fwd_busy = 2'b10; fwd_waddr[0] = 7; fwd_waddr[1] = 7;
        fwd_wdata[0] = 32'h11; fwd_wdata[1] = 32'h22;
        expect_out(0, 32'h11, 32'h11);
        ready_is("rdy_shadow", 1);
        step();

        // load-use hazard
        idle(); in_valid = 1; op2_sel = OP2_RS2; rs2_addr = 7;
        fwd_valid = 2'b01; fwd_busy = 2'b01; fwd_waddr[0] = 7;
        for (int i = 0; i < 2; i++) begin
            ready_is("rdy_haz", 0);
            step();
        end
        dchk("haz_valid", 32'(out_valid), 0);
        fwd_busy = 0; fwd_wdata[0] = 32'h55;
        expect_out(0, 32'h55, 32'h55);
        ready_is("rdy_haz_clear", 1);
        step();
        // store sees the rs2 hazard too
        op2_sel = OP2_IMS; imm_s_sext = 32'h10; fwd_busy = 2'b01;
        ready_is("rdy_store_haz", 0);
        step();
        // busy rs1 is irrelevant when op1 is PC
        idle(); in_valid = 1; op1_sel = OP1_PC; pc = 32'h300; rs1_addr = 3;
        op2_sel = OP2_IMI; imm_i_sext = 32'h8;
        fwd_valid = 2'b01; fwd_busy = 2'b01; fwd_waddr[0] = 3;
        expect_out(32'h300, 32'h8, 0);
        ready_is("rdy_unused_busy", 1);
        step();

        // backpressure hold
        idle(); in_valid = 1; op1_sel = OP1_PC; pc = 32'h200; op2_sel = OP2_IMU;
        imm_u_shifted = 32'h1234_5000; rs2_addr = 3; rs2_data = 32'h33;
        expect_out(32'h200, 32'h1234_5000, 32'h33); step();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h400 + i; imm_u_shifted = i; rs2_data = i;
            ready_is("rdy_hold", 0);
            step();
        end
        out_ready = 1; op1_sel = OP1_ZERO; op2_sel = OP2_IMS; imm_s_sext = 32'h7F0; rs2_addr = 0;
        expect_out(0, 32'h7F0, 0);
        ready_is("rdy_b2b", 1);
        step();
        // illegal encodings fall back to 0
        op1_sel = op1_sel_t'(2'd3); op2_sel = op2_sel_t'(3'd6); rs2_addr = 3; rs2_data = 32'h66;
        expect_out(0, 0, 32'h66); step();
        op1_sel = OP1_PC; pc = 32'h500; op2_sel = OP2_FOUR;
        expect_out(32'h500, 4, 32'h66); step();

        // flush kills held and incoming entries
        out_ready = 0; flush = 1; pc = 32'h510;
        ready_is("rdy_flush", 0);
        step();
        flush = 0; in_valid = 0;
        dchk("flush_valid", 32'(out_valid), 0);

        // reset during a stall
        idle(); in_valid = 1; op1_sel = OP1_PC; pc = 32'h600; op2_sel = OP2_IMI; imm_i_sext = 32'h9;
        expect_out(32'h600, 32'h9, 0); step();
        in_valid = 0; out_ready = 0; step();
        rst = 1; step();
        rst = 0; idle();
        dchk("rst2_valid", 32'(out_valid), 0);
        dchk("rst2_op1", out_op1, 0);
        dchk("rst2_op2", out_op2, 0);
        dchk("rst2_sd", out_store_data, 0);

`ifdef RISCV_OPERAND_STAGE_PERF_EN
        in_valid = 1; op2_sel = OP2_RS2; rs2_addr = 7;
        fwd_valid = 2'b01; fwd_busy = 2'b01; fwd_waddr[0] = 7;
        for (int i = 0; i < 4; i++) step();
        idle(); flush = 1;
        for (int i = 0; i < 2; i++) step();
        idle(); step();
        dchk("stall_cnt", stall_cnt, 4);
        dchk("flush_cnt", flush_cnt, 2);
`endif

        idle(); step(); step();
        dchk("sb_empty", exp_q.size(), 0);
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
